modcount: RTL and testbench
===========================

Name: modcount

Overview:
- Parametrised modulo-N up/down counter; next generation of the team's simple enable-only modulo incrementer.
- Adds:
  - programmable step size
  - count direction
  - synchronous clear and parallel load
  - wrap vs saturate mode
  - registered boundary-event flags
- Used as a generic event/index counter in cosimulation test designs.

Parameters:
- WIDTH, 16, width of count and load_value; intermediate arithmetic is WIDTH+1 bits.
- N, 8, modulus; count range 0..N-1; legal 2 <= N <= 2^WIDTH.
- STEP_W, 3, width of step input; constraint 2^STEP_W <= N, so step < N always.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  count-step qualifier
- up  in  1  direction: 1 = add step, 0 = subtract step
- step  in  STEP_W  step magnitude (0 allowed)
- saturate  in  1  mode: 1 = clamp at bounds, 0 = wrap modulo N
- clear  in  1  synchronous clear to 0
- load  in  1  synchronous parallel load
- load_value  in  WIDTH  value to load
- count  out  WIDTH  current count, registered
- wrap  out  1  registered pulse: last update wrapped (wrap mode)
- sat  out  1  registered pulse: last update was clamped (saturate mode)
- load_err  out  1  registered pulse: last load was out of range
- at_max  out  1  combinational, count == N-1
- at_zero  out  1  combinational, count == 0

Behaviour:
- **Reset.** reset low asynchronously forces count=0, wrap=0, sat=0, load_err=0, regardless of clock. Release is sampled at the next rising edge.
- **Update rule.** All updates occur on rising clock; count and flags update on the same edge (zero latency beyond the register).
- **Priority per edge:** clear > load > enable. Lower-priority requests in the same cycle are dropped.
- **Clear.** count=0; all pulse flags 0.
- **Load.**
  - load_value < N: count=load_value, load_err=0.
  - load_value >= N: count=N-1, load_err=1.
  - wrap=sat=0 in both cases.
- **Enable, up=1.** s = step; t = count + s, computed in WIDTH+1 bits.
  - t <= N-1: count=t.
  - t > N-1, saturate=0: count=t-N, wrap=1.
  - t > N-1, saturate=1: count=N-1, sat=1.
- **Enable, up=0.**
  - count >= s: count=count-s.
  - count < s, saturate=0: count=count+N-s, wrap=1.
  - count < s, saturate=1: count=0, sat=1.
- **step=0 with enable:** count unchanged; no flags.
- **Already at a bound in saturate mode:**
  - Stepping further into the bound (up at N-1 or down at 0 with step>0) holds count and sets sat=1 every such cycle.
  - Landing exactly on a bound without exceeding it does not set sat.
- **Idle (no clear/load/enable):** count holds; wrap/sat/load_err return to 0. Each flag is high only in the cycle after its causing edge.
- **Mode and direction inputs** (up, saturate) are sampled only on enable cycles; changing them between cycles is legal with no side effect.
- **Status outputs.** at_max/at_zero derive combinationally from the count register only; no input-to-output combinational path.
- **Mid-operation reset.** Asserting reset mid-operation discards any pending update. First enabled edge after release counts from 0.

Test Plan (N=8, WIDTH=16, STEP_W=3 unless stated):
1. Reset, then enable=1, up=1, step=1, saturate=0 for 10 cycles -> count 1,2,...,7,0,1,2; wrap=1 only in the cycle count becomes 0; at_max high when count=7.
2. From count=6, up=1, step=3, saturate=0 -> count=1, wrap=1. Then up=0, step=5 -> count=4 (1+8-5), wrap=1.
3. Saturate=1, count=5, up=1, step=4 -> count=7, sat=1; next cycle same -> count=7, sat=1. Then up=0, step=7 repeatedly -> 0, sat=0; then 0, sat=1.
4. load=1, load_value=3 -> count=3, load_err=0. load_value=9 -> count=7, load_err=1. Same cycle clear=1, load=1, enable=1 -> count=0, no flags.
5. Counting at count=4, assert reset low between edges -> count=0 immediately, flags 0. Release, then one enable edge with step=2, up=1 -> count=2.
6. N=10, WIDTH=4, STEP_W=3: up by 7 from 0 -> 7, 4 (wrap), 1 (wrap); down by 7 from 1 -> 4 (wrap); no width overflow at 4 bits.

Source files
------------

// File: rtl/modcount.sv
// modcount: modulo-N up/down counter with step, clear, load, wrap/saturate modes and registered event flags
// Ports: clock/reset (async active-low); enable/up/step/saturate drive counting;
// clear > load > enable; count, wrap, sat, load_err registered; at_max/at_zero decode count.
module modcount #(
  parameter int WIDTH  = 16,
  parameter int N      = 8,
  parameter int STEP_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              up,
  input  logic [STEP_W-1:0] step,
  input  logic              saturate,
  input  logic              clear,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  output logic [WIDTH-1:0]  count,
  output logic              wrap,
  output logic              sat,
  output logic              load_err,
  output logic              at_max,
  output logic              at_zero
);
  localparam logic [WIDTH:0]   NM   = (WIDTH+1)'(N);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(N - 1);
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d, sat_q, sat_d, load_err_q, load_err_d;
  logic [WIDTH:0]   c, s;
  logic             ov;
  assign c = {1'b0, count_q};
  assign s = (WIDTH+1)'(step);
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    sat_d      = 1'b0;
    load_err_d = 1'b0;
    ov         = 1'b0;
    if (clear) count_d = '0;
    else if (load) begin
      load_err_d = {1'b0, load_value} >= NM;
      count_d    = load_err_d ? MAXV : load_value;
    end else if (enable) begin
      // ov flags a step past the top (up) or below zero (down)
      ov      = up ? (c + s > {1'b0, MAXV}) : (c < s);
      count_d = !ov ? WIDTH'(up ? c + s : c - s) :
                saturate ? (up ? MAXV : '0) :
                WIDTH'(up ? c + s - NM : c + NM - s);
      wrap_d  = ov & ~saturate;
      sat_d   = ov & saturate;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      sat_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      sat_q      <= sat_d;
      load_err_q <= load_err_d;
    end
  end
  assign count    = count_q;
  assign wrap     = wrap_q;
  assign sat      = sat_q;
  assign load_err = load_err_q;
  assign at_max   = count_q == MAXV;
  assign at_zero  = count_q == '0;
endmodule

// File: tb/tb_modcount.sv
// tb_modcount: directed and random checks of modcount at N=8/WIDTH=16 and N=10/WIDTH=4
module tb_modcount;
  typedef struct packed {
    logic [15:0] c;
    logic        w;
    logic        s;
    logic        le;
  } exp_t;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0, up = 1'b0, saturate = 1'b0, clear = 1'b0, load = 1'b0;
  logic [2:0]  step = '0;
  logic [15:0] load_value = '0;
  logic [15:0] count8;
  logic [3:0]  count10;
  logic        wrap8, sat8, le8, max8, zero8;
  logic        wrap10, sat10, le10, max10, zero10;
  int          n_chk = 0;
  int          n_fail = 0;
  int          m8 = 0;
  int          m10 = 0;
  exp_t        q8[$];
  exp_t        q10[$];
  always #5 clock = ~clock;
  modcount #(.WIDTH(16), .N(8), .STEP_W(3)) dut8 (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .step(step),
    .saturate(saturate), .clear(clear), .load(load), .load_value(load_value),
    .count(count8), .wrap(wrap8), .sat(sat8), .load_err(le8),
    .at_max(max8), .at_zero(zero8)
  );
  modcount #(.WIDTH(4), .N(10), .STEP_W(3)) dut10 (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .step(step),
    .saturate(saturate), .clear(clear), .load(load), .load_value(load_value[3:0]),
    .count(count10), .wrap(wrap10), .sat(sat10), .load_err(le10),
    .at_max(max10), .at_zero(zero10)
  );
  function automatic exp_t model(input int n, input int c, input int lv);
    exp_t e;
    int   t;
    e = '0;
    if (clear) t = 0;
    else if (load) begin
      t    = (lv < n) ? lv : n - 1;
      e.le = lv >= n;
    end else if (enable && up) begin
      t = c + int'(step);
      if (t >= n) begin
        if (saturate) begin t = n - 1; e.s = 1'b1; end
        else begin t = t - n; e.w = 1'b1; end
      end
    end else if (enable) begin
      t = c - int'(step);
      if (t < 0) begin
        if (saturate) begin t = 0; e.s = 1'b1; end
        else begin t = t + n; e.w = 1'b1; end
      end
    end else t = c;
    e.c = 16'(t);
    return e;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input exp_t e8, input exp_t e10);
    chk({tag, " n8.count"}, {16'b0, count8}, {16'b0, e8.c});
    chk({tag, " n8.wrap"}, {31'b0, wrap8}, {31'b0, e8.w});
    chk({tag, " n8.sat"}, {31'b0, sat8}, {31'b0, e8.s});
    chk({tag, " n8.load_err"}, {31'b0, le8}, {31'b0, e8.le});
    chk({tag, " n8.at_max"}, {31'b0, max8}, {31'b0, e8.c == 16'd7});
    chk({tag, " n8.at_zero"}, {31'b0, zero8}, {31'b0, e8.c == 16'd0});
    chk({tag, " n10.count"}, {28'b0, count10}, {16'b0, e10.c});
    chk({tag, " n10.wrap"}, {31'b0, wrap10}, {31'b0, e10.w});
    chk({tag, " n10.sat"}, {31'b0, sat10}, {31'b0, e10.s});
    chk({tag, " n10.load_err"}, {31'b0, le10}, {31'b0, e10.le});
    chk({tag, " n10.at_max"}, {31'b0, max10}, {31'b0, e10.c == 16'd9});
    chk({tag, " n10.at_zero"}, {31'b0, zero10}, {31'b0, e10.c == 16'd0});
  endtask
  task automatic cyc(input string tag, input logic en, input logic u, input logic [2:0] st,
                     input logic sa, input logic cl, input logic ld, input logic [15:0] lv);
    exp_t e8, e10;
    enable = en; up = u; step = st; saturate = sa; clear = cl; load = ld; load_value = lv;
    q8.push_back(model(8, m8, int'(lv)));
    q10.push_back(model(10, m10, int'(lv[3:0])));
    @(posedge clock);
    #1;
    e8  = q8.pop_front();
    e10 = q10.pop_front();
    m8  = int'(e8.c);
    m10 = int'(e10.c);
    chk_all(tag, e8, e10);
  endtask
  initial begin
    #12;
    chk_all("reset", '0, '0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) cyc("up1", 1, 1, 1, 0, 0, 0, 0);
    chk("plan1 final", {16'b0, count8}, 32'd2);
    cyc("ld6", 0, 0, 0, 0, 0, 1, 6);
    cyc("up3wrap", 1, 1, 3, 0, 0, 0, 0);
    cyc("dn5wrap", 1, 0, 5, 0, 0, 0, 0);
    chk("plan2 dn5", {16'b0, count8}, 32'd4);
    cyc("ld5", 0, 0, 0, 0, 0, 1, 5);
    cyc("sat_up4", 1, 1, 4, 1, 0, 0, 0);
    cyc("sat_up4b", 1, 1, 4, 1, 0, 0, 0);
    cyc("sat_dn7", 1, 0, 7, 1, 0, 0, 0);
    cyc("sat_dn7b", 1, 0, 7, 1, 0, 0, 0);
    chk("plan3 sat hold", {31'b0, sat8}, 32'd1);
    cyc("step0", 1, 0, 0, 1, 0, 0, 0);
    cyc("ld3", 0, 0, 0, 0, 0, 1, 3);
    cyc("ld9", 0, 0, 0, 0, 0, 1, 9);
    chk("plan4 load_err", {31'b0, le8}, 32'd1);
    cyc("idle", 0, 1, 3, 0, 0, 0, 0);
    cyc("ld_big", 0, 0, 0, 0, 0, 1, 16'hffff);
    cyc("clr_pri", 1, 1, 3, 0, 1, 1, 5);
    cyc("ld_en", 1, 1, 3, 0, 0, 1, 2);
    cyc("ld4", 0, 0, 0, 0, 0, 1, 4);
    enable = 1; up = 1; step = 1;
    #3 reset = 1'b0;
    #1;
    m8 = 0; m10 = 0;
    chk_all("async_rst", '0, '0);
    #2 reset = 1'b1;
    cyc("post_rst", 1, 1, 2, 0, 0, 0, 0);
    chk("plan5 count", {16'b0, count8}, 32'd2);
    cyc("clr", 0, 0, 0, 0, 1, 0, 0);
    cyc("n10up7a", 1, 1, 7, 0, 0, 0, 0);
    cyc("n10up7b", 1, 1, 7, 0, 0, 0, 0);
    cyc("n10up7c", 1, 1, 7, 0, 0, 0, 0);
    chk("plan6 up", {28'b0, count10}, 32'd1);
    cyc("n10dn7", 1, 0, 7, 0, 0, 0, 0);
    chk("plan6 dn", {28'b0, count10}, 32'd4);
    cyc("ld9b", 0, 0, 0, 0, 0, 1, 9);
    cyc("n10max_up", 1, 1, 7, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++)
      cyc("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom),
          1'($urandom), 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
          16'($urandom_range(0, 12)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
